// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : data_mem_responder_pkg
// Brief  : Shared types for the MEM-stage data-memory responder: access size
//          codes, responder FSM states and the request legality check.
// Rev    : 1.0  initial release
// ============================================================================
package data_mem_responder_pkg;

  // Access size as carried on ReqSize.
  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  // Responder FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Returns 1 when a request must be answered with an error instead of
  // touching the RAM. The conditions are tested in priority order: illegal
  // size, then misalignment, then out-of-range word index.
  function automatic logic reqIsError(input size_e size,
                                      input logic [1:0] lane,
                                      input logic outOfRange);
    logic err;
    if (size == SZ_ILLEGAL) begin
      err = 1'b1;
    end else if ((size == SZ_HALF) && lane[0]) begin
      err = 1'b1;
    end else if ((size == SZ_WORD) && (lane != 2'b00)) begin
      err = 1'b1;
    end else begin
      err = outOfRange;
    end
    return err;
  endfunction

endpackage : data_mem_responder_pkg
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module : data_mem_if
// Brief  : Request/response channels between the MEM stage (master) and the
//          data-memory responder (slave).
//          Request : ReqValid/ReqReady handshake, ReqWrite, ReqSize,
//                    ReqSigned, ReqAddr, ReqWData.
//          Response: RspValid/RspReady handshake, RspRData, RspError.
// Rev    : 1.0  initial release
// ============================================================================
interface data_mem_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspRData;
  logic        RspError;

  // Pipeline side.
  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RspReady,
    input  ReqReady, RspValid, RspRData, RspError
  );

  // Responder side.
  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RspReady,
    output ReqReady, RspValid, RspRData, RspError
  );
endinterface : data_mem_if
`default_nettype wire

// File: rtl/data_mem_responder_mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_align
// Brief  : Combinational little-endian byte-lane steering for the data RAM.
//          Inputs : laneSel (addr[1:0]), size, loadSigned, rawWord (RAM word),
//                   wData (right-justified store data)
//          Outputs: byteEn (per-lane write enable), wrWord (store data placed
//                   on its lanes), loadData (extracted, extended load value)
// Rev    : 1.0  initial release
// ============================================================================
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  laneSel,
  input  size_e       size,
  input  logic        loadSigned,
  input  logic [31:0] rawWord,
  input  logic [31:0] wData,
  output logic [3:0]  byteEn,
  output logic [31:0] wrWord,
  output logic [31:0] loadData
);

  logic [31:0] w_shifted;

  // Bring the addressed lane down to bit 0 for loads.
  assign w_shifted = rawWord >> {laneSel, 3'b000};

  always_comb begin
    byteEn   = 4'b0000;
    wrWord   = 32'h0;
    loadData = 32'h0;
    case (size)
      SZ_BYTE: begin
        byteEn   = 4'b0001 << laneSel;
        // Replicating onto every lane lets byteEn pick the right one.
        wrWord   = {4{wData[7:0]}};
        loadData = {{24{loadSigned & w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        byteEn   = 4'b0011 << laneSel;
        wrWord   = {2{wData[15:0]}};
        loadData = {{16{loadSigned & w_shifted[15]}}, w_shifted[15:0]};
      end
      SZ_WORD: begin
        byteEn   = 4'b1111;
        wrWord   = wData;
        loadData = rawWord;
      end
      default: begin
        byteEn   = 4'b0000;
        wrWord   = 32'h0;
        loadData = 32'h0;
      end
    endcase
  end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : data_mem_responder
// Brief  : Responder end of the MEM-stage data-memory interface. Accepts one
//          load/store at a time, spends WAIT_STATES cycles waiting, performs
//          a single-cycle RAM access and holds the response until taken.
//          Clk   : rising-edge clock
//          Reset : asynchronous, active-high
//          bus   : data_mem_if.slave (request and response channels)
// Rev    : 1.0  initial release
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  data_mem_if.slave  bus
);

  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CNT_W       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_e            r_state;
  state_e            w_stateNext;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [CNT_W-1:0]  w_waitCntNext;

  // Latched request.
  logic              r_write;
  size_e             r_size;
  logic              r_signed;
  logic [1:0]        r_lane;
  logic [IDX_W-1:0]  r_wordIdx;
  logic [31:0]       r_wData;

  // Response registers.
  logic              r_rspValid;
  logic [31:0]       r_rspRData;
  logic              r_rspError;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_reqErr;
  logic              w_memWe;
  logic [3:0]        w_byteEn;
  logic [31:0]       w_wrWord;
  logic [31:0]       w_loadData;
  logic [31:0]       w_rawWord;

  assign bus.ReqReady = (r_state == S_IDLE);
  assign bus.RspValid = r_rspValid;
  assign bus.RspRData = r_rspRData;
  assign bus.RspError = r_rspError;

  assign w_accept = bus.ReqValid && (r_state == S_IDLE);
  // Checked on the live request so an error can skip WAIT/ACCESS entirely.
  assign w_reqErr = reqIsError(size_e'(bus.ReqSize), bus.ReqAddr[1:0],
                               bus.ReqAddr[31:2] >= DEPTH_LIMIT);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitCntNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_waitCntNext = r_waitCnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reqErr) begin
            w_stateNext = S_RESP;
          end else if (WAIT_STATES == 0) begin
            w_stateNext = S_ACCESS;
          end else begin
            w_stateNext   = S_WAIT;
            w_waitCntNext = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_waitCnt <= CNT_W'(1)) begin
          w_stateNext   = S_ACCESS;
          w_waitCntNext = '0;
        end else begin
          w_waitCntNext = r_waitCnt - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        w_stateNext = S_RESP;
      end
      S_RESP: begin
        if (bus.RspReady) begin
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_stateNext   = S_IDLE;
        w_waitCntNext = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latches and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_write    <= 1'b0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_lane     <= 2'b00;
      r_wordIdx  <= '0;
      r_wData    <= 32'h0;
      r_rspValid <= 1'b0;
      r_rspRData <= 32'h0;
      r_rspError <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write   <= bus.ReqWrite;
        r_size    <= size_e'(bus.ReqSize);
        r_signed  <= bus.ReqSigned;
        r_lane    <= bus.ReqAddr[1:0];
        r_wordIdx <= bus.ReqAddr[IDX_W+1:2];
        r_wData   <= bus.ReqWData;
        if (w_reqErr) begin
          r_rspValid <= 1'b1;
          r_rspRData <= 32'h0;
          r_rspError <= 1'b1;
        end
      end
      if (r_state == S_ACCESS) begin
        r_rspValid <= 1'b1;
        r_rspError <= 1'b0;
        r_rspRData <= r_write ? 32'h0 : w_loadData;
      end
      if ((r_state == S_RESP) && bus.RspReady) begin
        r_rspValid <= 1'b0;
        r_rspRData <= 32'h0;
        r_rspError <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM array (contents survive reset). Reset forces IDLE asynchronously, so
  // a store interrupted before ACCESS never reaches this write port.
  // --------------------------------------------------------------------------
  assign w_memWe   = (r_state == S_ACCESS) && r_write;
  assign w_rawWord = r_mem[r_wordIdx];

  always_ff @(posedge Clk) begin
    if (w_memWe) begin
      for (int k = 0; k < 4; k++) begin
        if (w_byteEn[k]) begin
          r_mem[r_wordIdx][8*k +: 8] <= w_wrWord[8*k +: 8];
        end
      end
    end
  end

  mem_lane_align u_align (
    .laneSel    (r_lane),
    .size       (r_size),
    .loadSigned (r_signed),
    .rawWord    (w_rawWord),
    .wData      (r_wData),
    .byteEn     (w_byteEn),
    .wrWord     (w_wrWord),
    .loadData   (w_loadData)
  );

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_responder
// Brief  : Self-checking bench for data_mem_responder (WAIT_STATES=2,
//          DEPTH_WORDS=1024). Vector table plus hand-written reset and
//          back-pressure sequences; expected responses queued at accept.
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 1024;

  logic Clk;
  logic Reset;
  int   cyc;
  int   total;
  int   passed;

  data_mem_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;        // edges from accept to RspValid, accept edge = 1
    int          acceptCyc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        w;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expR;
    logic        expE;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive a request and wait (bounded) for the accept edge; queue expectation.
  task automatic issue(input logic w, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] expR, input logic expE);
    bit   ok;
    exp_t e;
    ok = 0;
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = w;
    bus.ReqSize   = size;
    bus.ReqSigned = sgn;
    bus.ReqAddr   = addr;
    bus.ReqWData  = wdata;
    for (int i = 0; i < 20; i++) begin
      if (bus.ReqReady) begin
        @(posedge Clk); #1;
        ok = 1;
        break;
      end
      @(posedge Clk); #1;
    end
    bus.ReqValid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL accept timeout: addr 0x%08h never accepted", addr);
    end else begin
      e.rdata = expR;
      e.err = expE;
      e.lat = expE ? 1 : WS + 2;
      e.acceptCyc = cyc;
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for RspValid, then pop and compare.
  task automatic waitRsp(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.RspValid && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!bus.RspValid) begin
      total++;
      $display("FAIL %s timeout: RspValid 0 expected 1", name);
    end else if (sb.size() == 0) begin
      total++;
      $display("FAIL %s unexpected response: queue empty", name);
    end else begin
      e = sb.pop_front();
      check({name, " rdata"}, bus.RspRData, e.rdata);
      check({name, " error"}, {31'h0, bus.RspError}, {31'h0, e.err});
      check({name, " latency"}, cyc - e.acceptCyc + 1, e.lat);
    end
  endtask

  task automatic doReq(input string name, input logic w, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] expR, input logic expE);
    bus.RspReady = 1'b1;
    issue(w, size, sgn, addr, wdata, expR, expE);
    waitRsp(name);
    @(posedge Clk); #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    Reset  = 1'b1;
    bus.ReqValid  = 1'b0;
    bus.ReqWrite  = 1'b0;
    bus.ReqSize   = 2'b00;
    bus.ReqSigned = 1'b0;
    bus.ReqAddr   = 32'h0;
    bus.ReqWData  = 32'h0;
    bus.RspReady  = 1'b1;

    //            w     size   sgn   addr           wdata          expR          expE
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h80FF7F01, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'hFFFFFF80,  1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'h00000080,  1'b0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFF80FF,  1'b0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,        32'h00007F01,  1'b0};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h11223344, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'hFFFFFFAA, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        32'h1122AA44,  1'b0};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h1234BEEF, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        32'hBEEFAA44,  1'b0};
    vecs[12] = '{1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h12345678, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hFFFFFFFF, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'h12345678,  1'b0};
    vecs[16] = '{1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'hFFFFFFFF, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'h12345678,  1'b0};
    vecs[18] = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_0000, 1'b1};
    vecs[19] = '{1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'hCAFEF00D, 32'h0000_0000, 1'b0};
    vecs[20] = '{1'b0, 2'b00, 1'b1, 32'h0000_0FFF, 32'h0,        32'hFFFFFFCA,  1'b0};
    vecs[21] = '{1'b0, 2'b01, 1'b0, 32'h0000_0FFE, 32'h0,        32'h0000CAFE,  1'b0};
    vecs[22] = '{1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0,        32'h0000_0000, 1'b1};
    vecs[23] = '{1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFFFFFF,  1'b0};
    vecs[24] = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'h000080FF,  1'b0};
    vecs[25] = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        32'h00007F01,  1'b0};

    // ---- Reset state ----
    repeat (3) @(posedge Clk);
    #1;
    check("reset ReqReady", {31'h0, bus.ReqReady}, 32'd1);
    check("reset RspValid", {31'h0, bus.RspValid}, 32'd0);
    check("reset RspRData", bus.RspRData, 32'h0);
    check("reset RspError", {31'h0, bus.RspError}, 32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // ---- Reset during WAIT drops the store ----
    doReq("sw55", 1'b1, 2'b10, 1'b0, 32'h20, 32'h55, 32'h0, 1'b0);
    bus.RspReady = 1'b1;
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    sb.delete();
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    check("async reset ReqReady", {31'h0, bus.ReqReady}, 32'd1);
    check("async reset RspValid", {31'h0, bus.RspValid}, 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    doReq("lw after reset", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h55, 1'b0);

    // ---- Vector table ----
    for (int i = 0; i < NV; i++) begin
      doReq($sformatf("vec%0d", i), vecs[i].w, vecs[i].size, vecs[i].sgn,
            vecs[i].addr, vecs[i].wdata, vecs[i].expR, vecs[i].expE);
    end

    // ---- Response back-pressure ----
    bus.RspReady = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80FF7F01, 1'b0);
    waitRsp("hold lw");
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = 1'b0;
    bus.ReqSize   = 2'b10;
    bus.ReqSigned = 1'b0;
    bus.ReqAddr   = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check($sformatf("hold%0d RspValid", i), {31'h0, bus.RspValid}, 32'd1);
      check($sformatf("hold%0d RspRData", i), bus.RspRData, 32'h80FF7F01);
      check($sformatf("hold%0d ReqReady", i), {31'h0, bus.ReqReady}, 32'd0);
    end
    bus.RspReady = 1'b1;
    @(posedge Clk); #1;
    check("release RspValid", {31'h0, bus.RspValid}, 32'd0);
    check("release ReqReady", {31'h0, bus.ReqReady}, 32'd1);
    @(posedge Clk); #1;
    check("next accepted", {31'h0, bus.ReqReady}, 32'd0);
    begin
      exp_t e;
      e.rdata = 32'hBEEFAA44;
      e.err = 1'b0;
      e.lat = WS + 2;
      e.acceptCyc = cyc;
      sb.push_back(e);
    end
    bus.ReqValid = 1'b0;
    waitRsp("next lw");
    @(posedge Clk); #1;
    check("final RspValid", {31'h0, bus.RspValid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_data_mem_responder
`default_nettype wire
